// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, stage FSM encoding and default datapath width.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;
endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial-product step per cycle, WIDTH cycles after start.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, acc;

  // done and product are combinational so the final step's sum is visible in the same cycle
  assign product = acc + (b_q[0] ? a_q : '0);
  assign done    = busy && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      a_q  <= a;
      b_q  <= b;
    end else if (busy) begin
      acc <= product;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      cnt <= done ? '0 : cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/execute_alu_stage.sv
// Execute stage: single-cycle add/sub/slt, iterative mul with ready backpressure.
module execute_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       aluController,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic [TAG_W-1:0] rd_out
);
  alu_state_e       state;
  alu_op_e          op;
  logic [WIDTH-1:0] alu_res;
  logic [TAG_W-1:0] rd_q;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign op        = alu_op_e'(aluController);
  assign ready     = (state == IDLE);
  assign accept    = valid_in && ready && !flush;
  assign mul_start = accept && (op == ALU_MUL);

  always_comb begin
    alu_res = srcA + srcB;
    case (op)
      ALU_SUB: alu_res = srcA - srcB;
      ALU_SLT: alu_res = ($signed(srcA) < $signed(srcB)) ? WIDTH'(1) : '0;
      default: alu_res = srcA + srcB;
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush),
    .start   (mul_start),
    .a       (srcA),
    .b       (srcB),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      aluResult <= '0;
      zero      <= 1'b1;
      rd_out    <= '0;
      rd_q      <= '0;
    end else begin
      valid_out <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (op == ALU_MUL) begin
              state <= MUL;
              rd_q  <= rd_in;
            end else begin
              aluResult <= alu_res;
              zero      <= (alu_res == '0);
              rd_out    <= rd_in;
              valid_out <= 1'b1;
            end
          end
          MUL: if (mul_done) begin
            state     <= IDLE;
            aluResult <= mul_prod;
            zero      <= (mul_prod == '0);
            rd_out    <= rd_q;
            valid_out <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_execute_alu_stage.sv
// Directed bench for execute_alu_stage: single-cycle ops, mul latency, flush and reset.
module tb_execute_alu_stage;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, valid_in, flush;
  logic             ready, valid_out, zero;
  logic [1:0]       aluController;
  logic [WIDTH-1:0] srcA, srcB, aluResult;
  logic [TAG_W-1:0] rd_in, rd_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  execute_alu_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .ready         (ready),
    .aluController (aluController),
    .srcA          (srcA),
    .srcB          (srcB),
    .rd_in         (rd_in),
    .flush         (flush),
    .valid_out     (valid_out),
    .aluResult     (aluResult),
    .zero          (zero),
    .rd_out        (rd_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    valid_in = v; aluController = op; srcA = a; srcB = b; rd_in = rd;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    step(); step();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_result", aluResult, 0);
    chk("rst_zero", zero, 1);
    chk("rst_rd_out", rd_out, 0);
    rst = 1'b0;
    chk("ready_after_rst", ready, 1);

    // add 7+5
    drive(1'b1, 2'b00, 32'd7, 32'd5, 5'd3);
    step();
    chk("add_valid", valid_out, 1);
    chk("add_result", aluResult, 12);
    chk("add_zero", zero, 0);
    chk("add_rd", rd_out, 3);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    chk("add_pulse_end", valid_out, 0);
    chk("add_hold", aluResult, 12);

    // sub 5-5
    drive(1'b1, 2'b01, 32'd5, 32'd5, 5'd4);
    step();
    chk("sub_valid", valid_out, 1);
    chk("sub_result", aluResult, 0);
    chk("sub_zero", zero, 1);

    // slt -1 < 1, then 5 < -1
    drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd1, 5'd5);
    step();
    chk("slt_true", aluResult, 1);
    chk("slt_true_zero", zero, 0);
    drive(1'b1, 2'b11, 32'd5, 32'hFFFF_FFFF, 5'd6);
    step();
    chk("slt_false", aluResult, 0);

    // add wraps modulo 2^32
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1, 5'd8);
    step();
    chk("add_wrap", aluResult, 0);
    chk("add_wrap_zero", zero, 1);

    // flush in IDLE blocks acceptance
    flush = 1'b1;
    drive(1'b1, 2'b00, 32'd1, 32'd2, 5'd9);
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    chk("flush_idle_no_valid", valid_out, 0);
    chk("flush_idle_hold", aluResult, 0);

    // mul with operand toggling while busy, then back-to-back add
    drive(1'b1, 2'b10, 32'h0001_0003, 32'h0001_0002, 5'd7);
    step();
    for (int k = 1; k <= 32; k++) begin
      chk("mul_busy_ready", ready, 0);
      chk("mul_busy_valid", valid_out, 0);
      drive(1'b0, 2'b10, $urandom, $urandom, 5'd1);
      step();
    end
    chk("mul_valid", valid_out, 1);
    chk("mul_result", aluResult, 32'h0005_0006);
    chk("mul_rd", rd_out, 7);
    chk("mul_ready_after", ready, 1);
    drive(1'b1, 2'b00, 32'd7, 32'd5, 5'd9);
    step();
    chk("b2b_valid", valid_out, 1);
    chk("b2b_result", aluResult, 12);
    chk("b2b_rd", rd_out, 9);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);

    // flush mid-mul with valid_in asserted
    drive(1'b1, 2'b10, 32'd3, 32'd5, 5'd2);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 1; k < 10; k++) step();
    flush = 1'b1;
    drive(1'b1, 2'b00, 32'd1, 32'd1, 5'd2);
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    chk("flush_ready", ready, 1);
    for (int k = 11; k <= 40; k++) begin
      chk("flush_no_valid", valid_out, 0);
      step();
    end
    chk("flush_result_hold", aluResult, 12);

    // reset mid-mul
    drive(1'b1, 2'b10, 32'd3, 32'd5, 5'd11);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 1; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mul_valid", valid_out, 0);
    chk("rst_mul_result", aluResult, 0);
    chk("rst_mul_zero", zero, 1);
    chk("rst_mul_rd", rd_out, 0);
    chk("rst_mul_ready", ready, 1);
    for (int k = 7; k <= 40; k++) begin
      chk("rst_mul_no_valid", valid_out, 0);
      step();
    end

    // mul of all-ones operands: low word is 1
    drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 1; k <= 32; k++) step();
    chk("mul_ones_valid", valid_out, 1);
    chk("mul_ones_result", aluResult, 1);
    chk("mul_ones_rd", rd_out, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
